// File: rtl/axi_vga_lite_regs_if.sv
// AXI4-Lite S00_AXI bundle for the VGA register block; the master modport is
// the bus initiator, the slave modport is the register file.
interface axi_vga_lite_regs_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]                      S_AXI_AWPROT;
  logic                            S_AXI_AWVALID;
  logic                            S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                            S_AXI_WVALID;
  logic                            S_AXI_WREADY;
  logic [1:0]                      S_AXI_BRESP;
  logic                            S_AXI_BVALID;
  logic                            S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]                      S_AXI_ARPROT;
  logic                            S_AXI_ARVALID;
  logic                            S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                      S_AXI_RRESP;
  logic                            S_AXI_RVALID;
  logic                            S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );
endinterface

// File: rtl/axi_vga_lite_regs.sv
// AXI4-Lite slave holding the four VGA control registers and exporting them to the core.
// Optional macro AXI_VGA_LITE_WSTRB_EN enables per-byte writes via WSTRB.
module axi_vga_lite_regs #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 4,
  parameter logic [31:0] C_RESET_CTRL       = 32'h0000_0000
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  axi_vga_lite_regs_if.slave   s_axi,
  output logic [31:0]          vga_ctrl,
  output logic [31:0]          vga_bg_color,
  output logic [31:0]          vga_fb_base,
  output logic [31:0]          vga_timing,
  output logic [3:0]           vga_reg_wr
);

  localparam int DW = C_S_AXI_DATA_WIDTH;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state;
  r_state_t r_state;

  logic [DW-1:0] regs [4];

  logic          aw_ready, w_ready, b_valid;
  logic          ar_ready, r_valid;
  logic [DW-1:0] r_data;
  logic [3:0]    reg_wr;

  logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_in, ar_addr_in;
  logic          aw_hs, w_hs, wr_commit;
  logic [1:0]    aw_idx_q, wr_idx;
  logic [DW-1:0] wdata_q, wr_data, wr_word;

  assign aw_addr_in = s_axi.S_AXI_AWADDR;
  assign ar_addr_in = s_axi.S_AXI_ARADDR;
  assign aw_hs      = aw_ready & s_axi.S_AXI_AWVALID;
  assign w_hs       = w_ready  & s_axi.S_AXI_WVALID;

  // A half of the pair that arrived earlier comes from the holding registers.
  assign wr_idx  = (w_state == W_HAVE_ADDR) ? aw_idx_q : aw_addr_in[3:2];
  assign wr_data = (w_state == W_HAVE_DATA) ? wdata_q  : s_axi.S_AXI_WDATA;

`ifdef AXI_VGA_LITE_WSTRB_EN
  logic [3:0] wstrb_q, wr_strb;
  assign wr_strb = (w_state == W_HAVE_DATA) ? wstrb_q : s_axi.S_AXI_WSTRB;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_commit = 1'b0;
    unique case (w_state)
      W_IDLE:      wr_commit = aw_hs & w_hs;
      W_HAVE_ADDR: wr_commit = w_hs;
      W_HAVE_DATA: wr_commit = aw_hs;
      W_RESP:      wr_commit = 1'b0;
    endcase
  end

  always_comb begin
`ifdef AXI_VGA_LITE_WSTRB_EN
    wr_word = regs[wr_idx];
    for (int b = 0; b < 4; b++)
      if (wr_strb[b]) wr_word[8*b +: 8] = wr_data[8*b +: 8];
`else
    wr_word = wr_data;
`endif
  end

  // NOTE: holding registers are pure datapath and carry no reset; the FSM state alone
  // decides whether their content is meaningful, so a reset discards them implicitly.
  always_ff @(posedge ACLK) begin
    if (aw_hs) aw_idx_q <= aw_addr_in[3:2];
    if (w_hs) begin
      wdata_q <= s_axi.S_AXI_WDATA;
`ifdef AXI_VGA_LITE_WSTRB_EN
      wstrb_q <= s_axi.S_AXI_WSTRB;
`endif
    end
  end

  // Write channel; the register file lives here because it is reset and written by this FSM.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state  <= W_IDLE;
      aw_ready <= 1'b0;
      w_ready  <= 1'b0;
      b_valid  <= 1'b0;
      reg_wr   <= '0;
      // NOTE: the register file must come out of reset in a defined state, so unlike the
      // holding registers every entry is reset here.
      for (int i = 0; i < 4; i++) regs[i] <= (i == 0) ? C_RESET_CTRL : '0;
    end else begin
      reg_wr <= '0;
      if (wr_commit) begin
        regs[wr_idx] <= wr_word;
        reg_wr       <= 4'b0001 << wr_idx;
      end
      unique case (w_state)
        W_IDLE: begin
          if (aw_hs && w_hs) begin
            w_state  <= W_RESP;
            aw_ready <= 1'b0;
            w_ready  <= 1'b0;
            b_valid  <= 1'b1;
          end else if (aw_hs) begin
            w_state  <= W_HAVE_ADDR;
            aw_ready <= 1'b0;
            w_ready  <= 1'b1;
          end else if (w_hs) begin
            w_state  <= W_HAVE_DATA;
            aw_ready <= 1'b1;
            w_ready  <= 1'b0;
          end else begin
            aw_ready <= 1'b1;
            w_ready  <= 1'b1;
          end
        end
        W_HAVE_ADDR: begin
          if (w_hs) begin
            w_state <= W_RESP;
            w_ready <= 1'b0;
            b_valid <= 1'b1;
          end
        end
        W_HAVE_DATA: begin
          if (aw_hs) begin
            w_state  <= W_RESP;
            aw_ready <= 1'b0;
            b_valid  <= 1'b1;
          end
        end
        W_RESP: begin
          if (s_axi.S_AXI_BREADY) begin
            w_state  <= W_IDLE;
            b_valid  <= 1'b0;
            aw_ready <= 1'b1;
            w_ready  <= 1'b1;
          end
        end
      endcase
    end
  end

  // Read channel; sampling regs here on the commit edge naturally returns the pre-write value.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state  <= R_IDLE;
      ar_ready <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= '0;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          if (ar_ready && s_axi.S_AXI_ARVALID) begin
            r_state  <= R_DATA;
            r_data   <= regs[ar_addr_in[3:2]];
            r_valid  <= 1'b1;
            ar_ready <= 1'b0;
          end else begin
            ar_ready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi.S_AXI_RREADY) begin
            r_state  <= R_IDLE;
            r_valid  <= 1'b0;
            ar_ready <= 1'b1;
          end
        end
      endcase
    end
  end

  assign s_axi.S_AXI_AWREADY = aw_ready;
  assign s_axi.S_AXI_WREADY  = w_ready;
  assign s_axi.S_AXI_BVALID  = b_valid;
  assign s_axi.S_AXI_BRESP   = 2'b00;
  assign s_axi.S_AXI_ARREADY = ar_ready;
  assign s_axi.S_AXI_RVALID  = r_valid;
  assign s_axi.S_AXI_RDATA   = r_data;
  assign s_axi.S_AXI_RRESP   = 2'b00;

  assign vga_ctrl     = regs[0];
  assign vga_bg_color = regs[1];
  assign vga_fb_base  = regs[2];
  assign vga_timing   = regs[3];
  assign vga_reg_wr   = reg_wr;

  // Protection bits, byte-offset bits and aliased upper address bits carry no meaning here.
  logic unused_ok;
`ifdef AXI_VGA_LITE_WSTRB_EN
  assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, aw_addr_in, ar_addr_in};
`else
  assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, aw_addr_in, ar_addr_in,
                       s_axi.S_AXI_WSTRB};
`endif

endmodule

// File: tb/tb_axi_vga_lite_regs.sv
// Directed bench for axi_vga_lite_regs: table of write/read vectors plus hand sequences
// for stalls, ordering, strobes and mid-transaction reset.
module tb_axi_vga_lite_regs;

  localparam logic [31:0] RESET_CTRL = 32'hA5A5_0001;

  logic        tb_ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] vga_ctrl, vga_bg_color, vga_fb_base, vga_timing;
  logic [3:0]  vga_reg_wr;

  int checks = 0;
  int errors = 0;

  always #5 tb_ACLK = ~tb_ACLK;

  axi_vga_lite_regs_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) bus ();

  axi_vga_lite_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4),
    .C_RESET_CTRL(RESET_CTRL)
  ) dut (
    .ACLK(tb_ACLK),
    .ARESET(ARESET),
    .s_axi(bus.slave),
    .vga_ctrl(vga_ctrl),
    .vga_bg_color(vga_bg_color),
    .vga_fb_base(vga_fb_base),
    .vga_timing(vga_timing),
    .vga_reg_wr(vga_reg_wr)
  );

  typedef struct {
    bit          is_wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;   // reg_wr pulse for writes, read data for reads
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge tb_ACLK);
    @(negedge tb_ACLK);
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_delay, input int w_delay,
                           output logic [3:0] wr_pulse, output bit early_b);
    bit aw_done = 0, w_done = 0, aw_fire, w_fire;
    int cyc = 0;
    early_b = 0;
    bus.S_AXI_AWADDR = addr;
    bus.S_AXI_WDATA  = data;
    bus.S_AXI_WSTRB  = strb;
    while (!(aw_done && w_done) && cyc < 40) begin
      if (!aw_done) bus.S_AXI_AWVALID = (cyc >= aw_delay);
      if (!w_done)  bus.S_AXI_WVALID  = (cyc >= w_delay);
      aw_fire = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      w_fire  = bus.S_AXI_WVALID  && bus.S_AXI_WREADY;
      if (bus.S_AXI_BVALID) early_b = 1;
      cycle();
      if (aw_fire) begin aw_done = 1; bus.S_AXI_AWVALID = 0; end
      if (w_fire)  begin w_done  = 1; bus.S_AXI_WVALID  = 0; end
      cyc++;
    end
    check("write_handshakes_done", 32'(aw_done && w_done), 32'd1);
    wr_pulse = vga_reg_wr;
  endtask

  task automatic b_phase(input int hold);
    int  n = 0;
    bit  stall_ok = 1;
    while (!bus.S_AXI_BVALID && n < 20) begin cycle(); n++; end
    check("bvalid_high", 32'(bus.S_AXI_BVALID), 32'd1);
    check("bresp_okay", 32'(bus.S_AXI_BRESP), 32'd0);
    for (int i = 0; i < hold; i++) begin
      cycle();
      if (!bus.S_AXI_BVALID || bus.S_AXI_AWREADY || bus.S_AXI_WREADY) stall_ok = 0;
    end
    if (hold > 0) check("b_stall_hold", 32'(stall_ok), 32'd1);
    bus.S_AXI_BREADY = 1;
    cycle();
    bus.S_AXI_BREADY = 0;
    check("bvalid_drop", 32'(bus.S_AXI_BVALID), 32'd0);
  endtask

  task automatic axi_read(input logic [3:0] addr, input int hold, output logic [31:0] data);
    int n = 0;
    bit stall_ok = 1;
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARVALID = 1;
    while (!bus.S_AXI_ARREADY && n < 20) begin cycle(); n++; end
    check("arready_high", 32'(bus.S_AXI_ARREADY), 32'd1);
    cycle();
    bus.S_AXI_ARVALID = 0;
    check("rvalid_next_cycle", 32'(bus.S_AXI_RVALID), 32'd1);
    check("rresp_okay", 32'(bus.S_AXI_RRESP), 32'd0);
    data = bus.S_AXI_RDATA;
    for (int i = 0; i < hold; i++) begin
      cycle();
      if (!bus.S_AXI_RVALID || bus.S_AXI_ARREADY || bus.S_AXI_RDATA !== data) stall_ok = 0;
    end
    if (hold > 0) check("r_stall_hold", 32'(stall_ok), 32'd1);
    bus.S_AXI_RREADY = 1;
    cycle();
    bus.S_AXI_RREADY = 0;
    check("rvalid_drop", 32'(bus.S_AXI_RVALID), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  pulse;
    logic [31:0] rd;
    bit          early_b;

    vecs[0] = '{1'b1, 4'h0, 32'h0101_FFFF, 4'hF, 32'h1};
    vecs[1] = '{1'b0, 4'h0, 32'h0,         4'h0, 32'h0101_FFFF};
    vecs[2] = '{1'b1, 4'h4, 32'hABCD_0001, 4'hF, 32'h2};
    vecs[3] = '{1'b0, 4'h4, 32'h0,         4'h0, 32'hABCD_0001};
    vecs[4] = '{1'b1, 4'h8, 32'hDEAD_0011, 4'hF, 32'h4};
    vecs[5] = '{1'b0, 4'h8, 32'h0,         4'h0, 32'hDEAD_0011};
    vecs[6] = '{1'b1, 4'hC, 32'hBEEF_0011, 4'hF, 32'h8};
    vecs[7] = '{1'b0, 4'hC, 32'h0,         4'h0, 32'hBEEF_0011};

    ARESET = 1;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 0;
    bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB  = '0; bus.S_AXI_WVALID  = 0;
    bus.S_AXI_BREADY = 0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 0;
    bus.S_AXI_RREADY = 0;

    // Reset state
    repeat (3) @(posedge tb_ACLK);
    @(negedge tb_ACLK);
    check("rst_readies", {29'd0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 32'd0);
    check("rst_valids", {30'd0, bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 32'd0);
    check("rst_rdata", bus.S_AXI_RDATA, 32'd0);
    check("rst_vga_ctrl", vga_ctrl, RESET_CTRL);
    check("rst_vga_others", vga_bg_color | vga_fb_base | vga_timing, 32'd0);
    check("rst_reg_wr", 32'(vga_reg_wr), 32'd0);
    ARESET = 0;
    cycle();
    check("ready_after_reset", {29'd0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 32'd7);

    // Table: write each register then read it back
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].is_wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, pulse, early_b);
        check($sformatf("vec%0d_reg_wr", i), 32'(pulse), vecs[i].exp);
        b_phase(0);
      end else begin
        axi_read(vecs[i].addr, 0, rd);
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
      end
    end
    check("vga_ctrl_out", vga_ctrl, 32'h0101_FFFF);
    check("vga_bg_out", vga_bg_color, 32'hABCD_0001);
    check("vga_fb_out", vga_fb_base, 32'hDEAD_0011);
    check("vga_timing_out", vga_timing, 32'hBEEF_0011);

    // W leads AW by 3 cycles, then AW leads W by 3 cycles
    axi_write(4'h4, 32'h5A5A_5A5A, 4'hF, 3, 0, pulse, early_b);
    check("wlead_no_early_b", 32'(early_b), 32'd0);
    check("wlead_reg_wr", 32'(pulse), 32'h2);
    check("wlead_bg", vga_bg_color, 32'h5A5A_5A5A);
    cycle();
    check("wlead_pulse_one_cycle", 32'(vga_reg_wr), 32'd0);
    b_phase(0);
    axi_write(4'h4, 32'h1234_5678, 4'hF, 0, 3, pulse, early_b);
    check("awlead_no_early_b", 32'(early_b), 32'd0);
    check("awlead_reg_wr", 32'(pulse), 32'h2);
    check("awlead_bg", vga_bg_color, 32'h1234_5678);
    cycle();
    check("awlead_pulse_one_cycle", 32'(vga_reg_wr), 32'd0);
    b_phase(0);

    // BREADY low 5 cycles with a second write already offered
    axi_write(4'hC, 32'h0BAD_0003, 4'hF, 0, 0, pulse, early_b);
    bus.S_AXI_AWADDR = 4'hC; bus.S_AXI_WDATA = 32'h0000_0033; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_AWVALID = 1; bus.S_AXI_WVALID = 1;
    b_phase(5);
    check("second_wr_ready", {30'd0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 32'd3);
    check("second_wr_not_yet", vga_timing, 32'h0BAD_0003);
    cycle();
    bus.S_AXI_AWVALID = 0; bus.S_AXI_WVALID = 0;
    check("second_wr_done", vga_timing, 32'h0000_0033);
    check("second_wr_pulse", 32'(vga_reg_wr), 32'h8);
    b_phase(0);
    axi_read(4'hC, 0, rd);
    check("second_wr_readback", rd, 32'h0000_0033);

    // RREADY low 4 cycles
    axi_read(4'h8, 4, rd);
    check("rstall_rdata", rd, 32'hDEAD_0011);

    // Byte strobes
    axi_write(4'h0, 32'hFFFF_FFFF, 4'hF, 0, 0, pulse, early_b);
    b_phase(0);
    axi_write(4'h0, 32'h0000_0000, 4'b0101, 0, 0, pulse, early_b);
    check("strb_reg_wr", 32'(pulse), 32'h1);
    b_phase(0);
    axi_read(4'h0, 0, rd);
`ifdef AXI_VGA_LITE_WSTRB_EN
    check("strb_readback", rd, 32'hFF00_FF00);
`else
    check("strb_readback", rd, 32'h0000_0000);
`endif

    // Simultaneous write and read of reg1: read sees pre-write value
    check("sim_readies", {29'd0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 32'd7);
    bus.S_AXI_AWADDR = 4'h4; bus.S_AXI_WDATA = 32'h0F0F_0F0F; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_ARADDR = 4'h4;
    bus.S_AXI_AWVALID = 1; bus.S_AXI_WVALID = 1; bus.S_AXI_ARVALID = 1;
    cycle();
    bus.S_AXI_AWVALID = 0; bus.S_AXI_WVALID = 0; bus.S_AXI_ARVALID = 0;
    check("sim_rvalid", 32'(bus.S_AXI_RVALID), 32'd1);
    check("sim_rdata_old", bus.S_AXI_RDATA, 32'h1234_5678);
    check("sim_bg_new", vga_bg_color, 32'h0F0F_0F0F);
    bus.S_AXI_BREADY = 1; bus.S_AXI_RREADY = 1;
    cycle();
    bus.S_AXI_BREADY = 0; bus.S_AXI_RREADY = 0;
    check("sim_both_done", {30'd0, bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 32'd0);

    // Reset pulse while BVALID pending
    axi_write(4'hC, 32'hCAFE_F00D, 4'hF, 0, 0, pulse, early_b);
    check("cafe_written", vga_timing, 32'hCAFE_F00D);
    ARESET = 1;
    cycle();
    ARESET = 0;
    check("rst_mid_bvalid", 32'(bus.S_AXI_BVALID), 32'd0);
    check("rst_mid_awready", 32'(bus.S_AXI_AWREADY), 32'd0);
    check("rst_mid_timing", vga_timing, 32'd0);
    axi_read(4'hC, 0, rd);
    check("rst_mid_reg3", rd, 32'd0);
    axi_read(4'h0, 0, rd);
    check("rst_mid_reg0", rd, RESET_CTRL);

    // Half-latched AW discarded by reset
    bus.S_AXI_AWADDR = 4'h8; bus.S_AXI_AWVALID = 1;
    cycle();
    bus.S_AXI_AWVALID = 0;
    ARESET = 1;
    cycle();
    ARESET = 0;
    cycle();
    bus.S_AXI_WDATA = 32'h7777_7777; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1;
    cycle();
    bus.S_AXI_WVALID = 0;
    check("half_aw_no_b", 32'(bus.S_AXI_BVALID), 32'd0);
    check("half_aw_fb_untouched", vga_fb_base, 32'd0);
    check("half_aw_wait_addr", {30'd0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 32'd2);
    bus.S_AXI_AWADDR = 4'h0; bus.S_AXI_AWVALID = 1;
    cycle();
    bus.S_AXI_AWVALID = 0;
    check("half_aw_ctrl", vga_ctrl, 32'h7777_7777);
    check("half_aw_pulse", 32'(vga_reg_wr), 32'h1);
    b_phase(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_vga_lite_regs.md
Name: axi_vga_lite_regs

Overview:
- AXI4-Lite slave register file on the S00_AXI port of the VGA IP; it is the responder that the AXI4-Lite master issues register writes and reads to.
- Holds 4 × 32-bit read/write control registers (control, background colour, framebuffer base, timing).
- Exports the register contents to the VGA timing/pixel core.
- Write and read channels are independent FSMs; single outstanding transaction per channel.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, address width; index = ADDR[3:2], ADDR[1:0] ignored.
- C_RESET_CTRL, 32'h0000_0000, reset value of reg0. reg1..reg3 reset to 0.

Ports:
- ACLK  in  1  clock
- ARESET  in  1  synchronous active-high reset
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID  in  1  write address valid
- S_AXI_AWREADY  out  1  write address ready
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte strobes
- S_AXI_WVALID  in  1  write data valid
- S_AXI_WREADY  out  1  write data ready
- S_AXI_BRESP  out  2  write response, always 2'b00
- S_AXI_BVALID  out  1  write response valid
- S_AXI_BREADY  in  1  write response ready
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID  in  1  read address valid
- S_AXI_ARREADY  out  1  read address ready
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  read response, always 2'b00
- S_AXI_RVALID  out  1  read data valid
- S_AXI_RREADY  in  1  read data ready
- vga_ctrl  out  32  reg0
- vga_bg_color  out  32  reg1
- vga_fb_base  out  32  reg2
- vga_timing  out  32  reg3
- vga_reg_wr  out  4  one-cycle pulse per register written

Behaviour:
- Clock and reset: single clock ACLK; reset is synchronous and active-high (ARESET). Reset is sampled only on the ACLK rising edge.
- Reset values: all READY/VALID outputs 0; RDATA 0; BRESP/RRESP 00; reg0 = C_RESET_CTRL; reg1..reg3 = 0; vga_reg_wr = 0. Both FSMs return to idle.
- All outputs are registered. READY signals first rise in the cycle after ARESET deasserts.

Write FSM states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
- AWREADY = 1 in W_IDLE and W_HAVE_DATA; WREADY = 1 in W_IDLE and W_HAVE_ADDR; both 0 in W_RESP.
- W_IDLE:
  - AW and W handshake in the same cycle → W_RESP.
  - AW only → latch address, go to W_HAVE_ADDR.
  - W only → latch data and strobe, go to W_HAVE_DATA.
- W_HAVE_ADDR + W handshake → W_RESP. W_HAVE_DATA + AW handshake → W_RESP.
- On entry to W_RESP (the edge that completes the pair):
  - The register is updated.
  - vga_reg_wr[idx] pulses for 1 cycle.
  - BVALID rises.
  - Updated value visible on vga_* outputs in the following cycle.
- W_RESP: hold BVALID and BRESP=00 until BREADY=1. On the BVALID&BREADY edge, BVALID drops → W_IDLE. Earliest next AWREADY is the following cycle.
- Minimum write: 2 cycles handshake-to-handshake when BREADY is held high.

Read FSM states: R_IDLE, R_DATA.
- ARREADY = 1 only in R_IDLE.
- AR handshake → RDATA = reg[ARADDR[3:2]], RVALID = 1 in the next cycle → R_DATA.
- R_DATA: RDATA and RVALID stay stable until RREADY=1; then RVALID drops → R_IDLE.

Boundary and ordering rules:
- Simultaneous write and read of the same register on one edge: read captures the pre-write value.
- Reset mid-transaction: any half-latched AW or W is discarded, pending B/R is dropped, registers return to reset values.
- Address aliasing: upper address bits beyond [3:2] are ignored. Every access returns OKAY.

Optional Feature:
- Macro: AXI_VGA_LITE_WSTRB_EN.
- Defined: per-byte write; byte b of the register is updated only if WSTRB[b]=1. vga_reg_wr pulses even if WSTRB=0000.
- Undefined: WSTRB is ignored and every write updates all 32 bits.

Test Plan:
- Four sequential writes to offsets 0x0/0x4/0x8/0xC with 0x0101FFFF, 0xabcd0001, 0xdead0011, 0xbeef0011, each followed by a read of the same offset → BRESP=RRESP=00, each read data equals the written word, vga_* outputs match.
- AWVALID asserted 3 cycles before WVALID (then reversed) writing 0x12345678 to 0x4 → single BVALID after both handshakes; vga_bg_color=0x12345678; vga_reg_wr=0010 for exactly 1 cycle.
- BREADY held low 5 cycles after a write → BVALID stays high, AWREADY/WREADY stay 0 throughout, second write is accepted only after the B handshake.
- RREADY held low 4 cycles on a read of 0x8 → RDATA stable at 0xdead0011 with RVALID high; ARREADY stays 0 until the R handshake.
- With AXI_VGA_LITE_WSTRB_EN, reg0=0xFFFFFFFF, write 0x00000000 with WSTRB=0101 → reads 0xFF00FF00. Without the macro, the same write → reads 0x00000000.
- ARESET pulsed 1 cycle while BVALID is pending after writing 0xCAFEF00D to 0xC → BVALID=0 next cycle, reg3 reads 0x00000000, reg0 reads C_RESET_CTRL.
